// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: register tags and stage status in, stall/flush/forward controls out.
interface hazard_ctrl_if;
    logic [4:0]  Rs1_d, Rs2_d;
    logic [4:0]  Rs1_e, Rs2_e, Rd_e;
    logic [1:0]  ResultSrc_e;
    logic [4:0]  Rd_m, Rd_w;
    logic        RegWrite_m, RegWrite_w;
    logic        PCSrc_e;
    logic        cache_miss_m;
    logic        cache_ready;

    logic        en_f, en_d, en_e, en_m;
    logic        flush_d_n, flush_e_n;
    logic [1:0]  ForwardA_e, ForwardB_e;
    logic [15:0] miss_cycles, loaduse_stalls;
    logic        state_o;

    // The pipeline side drives register tags and stage status.
    modport master (
        output Rs1_d, Rs2_d, Rs1_e, Rs2_e, Rd_e, ResultSrc_e,
               Rd_m, Rd_w, RegWrite_m, RegWrite_w, PCSrc_e,
               cache_miss_m, cache_ready,
        input  en_f, en_d, en_e, en_m, flush_d_n, flush_e_n,
               ForwardA_e, ForwardB_e, miss_cycles, loaduse_stalls, state_o
    );

    modport slave (
        input  Rs1_d, Rs2_d, Rs1_e, Rs2_e, Rd_e, ResultSrc_e,
               Rd_m, Rd_w, RegWrite_m, RegWrite_w, PCSrc_e,
               cache_miss_m, cache_ready,
        output en_f, en_d, en_e, en_m, flush_d_n, flush_e_n,
               ForwardA_e, ForwardB_e, miss_cycles, loaduse_stalls, state_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: cache-miss freeze FSM, load-use bubble, branch flush,
// operand forwarding and saturating stall counters.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [0:0] ST_RUN       = 1'b0;
    localparam logic [0:0] ST_MISS_WAIT = 1'b1;
    localparam logic [1:0] RES_LOAD     = 2'b01;
    localparam logic [1:0] FWD_RF       = 2'b00;
    localparam logic [1:0] FWD_MEM      = 2'b10;
    localparam logic [1:0] FWD_WB       = 2'b01;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    logic [0:0]  state_q, state_d;
    logic [15:0] miss_cycles_q, loaduse_stalls_q;
    logic        freeze, load_use, bubble;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.RegWrite_m && (hz.Rd_m != 5'd0) && (hz.Rd_m == rs))
            return FWD_MEM;
        else if (hz.RegWrite_w && (hz.Rd_w != 5'd0) && (hz.Rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:       if (hz.cache_miss_m) state_d = ST_MISS_WAIT;
            ST_MISS_WAIT: if (hz.cache_ready)  state_d = ST_RUN;
            default:      state_d = ST_RUN;
        endcase
    end

    // The freeze covers the miss-detect cycle and the refill-complete cycle alike.
    assign freeze   = (state_q == ST_MISS_WAIT) || hz.cache_miss_m;
    assign load_use = (hz.ResultSrc_e == RES_LOAD) && (hz.Rd_e != 5'd0) &&
                      ((hz.Rd_e == hz.Rs1_d) || (hz.Rd_e == hz.Rs2_d));
    assign bubble   = rst_n && !freeze && !hz.PCSrc_e && load_use;

    always_comb begin
        hz.en_f       = 1'b1;
        hz.en_d       = 1'b1;
        hz.en_e       = 1'b1;
        hz.en_m       = 1'b1;
        hz.flush_d_n  = 1'b1;
        hz.flush_e_n  = 1'b1;
        hz.ForwardA_e = fwd_sel(hz.Rs1_e);
        hz.ForwardB_e = fwd_sel(hz.Rs2_e);
        if (!rst_n) begin
            // Pipeline registers clear on the same edge as the hazard state.
            hz.flush_d_n  = 1'b0;
            hz.flush_e_n  = 1'b0;
            hz.ForwardA_e = FWD_RF;
            hz.ForwardB_e = FWD_RF;
        end else if (freeze) begin
            hz.en_f = 1'b0;
            hz.en_d = 1'b0;
            hz.en_e = 1'b0;
            hz.en_m = 1'b0;
        end else if (hz.PCSrc_e) begin
            hz.flush_d_n = 1'b0;
            hz.flush_e_n = 1'b0;
        end else if (load_use) begin
            hz.en_f      = 1'b0;
            hz.en_d      = 1'b0;
            hz.flush_e_n = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            miss_cycles_q    <= '0;
            loaduse_stalls_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_MISS_WAIT) && (miss_cycles_q != CNT_MAX))
                miss_cycles_q <= miss_cycles_q + 16'd1;
            if (bubble && (loaduse_stalls_q != CNT_MAX))
                loaduse_stalls_q <= loaduse_stalls_q + 16'd1;
        end
    end

    assign hz.miss_cycles    = miss_cycles_q;
    assign hz.loaduse_stalls = loaduse_stalls_q;
    assign hz.state_o        = state_q[0];
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: Rs1_d, Rs2_d  in  5 each  source registers of the instruction in decode.
REQ-004 SHALL have ports: Rs1_e, Rs2_e, Rd_e  in  5 each  source and destination registers in execute.
REQ-005 SHALL have port: ResultSrc_e  in  2  execute result select; 2'b01 means load.
REQ-006 SHALL have ports: Rd_m, RegWrite_m, Rd_w, RegWrite_w  in  5/1/5/1  memory-stage and writeback-stage destination register and write enable.
REQ-007 SHALL have port: PCSrc_e  in  1  branch taken or jump resolved in execute.
REQ-008 SHALL have ports: cache_miss_m  in  1  data-cache miss on the memory-stage access; cache_ready  in  1  refill complete, one-cycle pulse.
REQ-009 SHALL have ports: en_f, en_d, en_e, en_m  out  1 each  active-high enables for PC, fetch/decode, decode/execute, execute/memory registers.
REQ-010 SHALL have ports: flush_d_n, flush_e_n  out  1 each  active-low flush for fetch/decode and decode/execute registers.
REQ-011 SHALL have ports: ForwardA_e, ForwardB_e  out  2 each  ALU operand select: 00 register file, 10 memory-stage result, 01 writeback result.
REQ-012 SHALL have ports: miss_cycles, loaduse_stalls  out  16 each  saturating performance counters; state_o  out  1  0 = RUN, 1 = MISS_WAIT.

Function
REQ-013 SHALL implement a two-state FSM, RUN and MISS_WAIT, held in a register.
REQ-014 In RUN, with cache_miss_m=1 at a clock edge, SHALL move to MISS_WAIT.
REQ-015 In MISS_WAIT, with cache_ready=1 at a clock edge, SHALL move to RUN; cache_miss_m SHALL be ignored in MISS_WAIT.
REQ-016 The miss freeze condition is cache_miss_m=1 in RUN, or state=MISS_WAIT.
- While it holds, en_f=en_d=en_e=en_m=0 and flush_d_n=flush_e_n=1, combinationally.
- This includes the cycle in which cache_ready=1.
REQ-017 The load-use condition is ResultSrc_e=01, Rd_e!=0, and Rd_e equal to Rs1_d or Rs2_d.
REQ-018 With load-use and no freeze: en_f=0, en_d=0, flush_e_n=0; en_e and en_m stay 1 (one-cycle bubble).
REQ-019 With PCSrc_e=1 and no freeze: flush_d_n=0, flush_e_n=0; enables stay 1.
REQ-020 Priority SHALL be freeze > PCSrc_e > load-use.
- With PCSrc_e and load-use in the same cycle, en_f=en_d=1 and both flushes are 0.
- loaduse_stalls SHALL NOT increment in that case.
REQ-021 With no condition active: all enables = 1 and both flushes = 1.
REQ-022 ForwardA_e SHALL be set combinationally, first match wins:
- 10 if RegWrite_m=1, Rd_m!=0 and Rd_m==Rs1_e;
- else 01 if RegWrite_w=1, Rd_w!=0 and Rd_w==Rs1_e;
- else 00.
REQ-023 ForwardB_e SHALL follow the same rule using Rs2_e; forwarding SHALL be unaffected by freeze.
REQ-024 miss_cycles SHALL increment by 1 on each edge where state=MISS_WAIT and saturate at 16'hFFFF.
REQ-025 loaduse_stalls SHALL increment by 1 on each edge where the REQ-018 bubble is applied and saturate at 16'hFFFF.
REQ-026 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-027 On a rising edge with rst_n=0: state=RUN, miss_cycles=0, loaduse_stalls=0, regardless of current state.
- This applies mid-miss; a pending cache_ready is then ignored.
REQ-028 While rst_n=0: flush_d_n=0, flush_e_n=0, all enables = 1, ForwardA_e=ForwardB_e=00, so pipeline registers clear on the same edge.
REQ-029 After rst_n returns to 1, outputs SHALL follow REQ-016..REQ-023 from the next cycle.

Verification
REQ-030 Load-use: ResultSrc_e=01, Rd_e=5, Rs2_d=5 for one cycle -> en_f=en_d=0, flush_e_n=0, en_e=1; loaduse_stalls 0->1.
REQ-031 Miss: cache_miss_m=1 for 1 cycle, cache_ready pulsed 4 cycles later -> enables 0 for 5 cycles, state_o=1 for 4 cycles, miss_cycles=4, RUN afterwards.
REQ-032 Forwarding: RegWrite_m=1, Rd_m=7, RegWrite_w=1, Rd_w=7, Rs1_e=7, Rs2_e=0 -> ForwardA_e=10, ForwardB_e=00.
REQ-033 Branch with load-use: PCSrc_e=1 while the load-use condition holds -> flush_d_n=0, flush_e_n=0, en_f=1, loaduse_stalls unchanged.
REQ-034 Reset mid-miss: rst_n=0 for 1 edge during MISS_WAIT -> state_o=0, both counters 0, flush_d_n=flush_e_n=0 during reset.
REQ-035 Saturation: force 65540 MISS_WAIT cycles -> miss_cycles=16'hFFFF, no wrap.
